// File: rtl/tt_um_prg_core.sv
// Boolean pseudo-random generator: 32-bit Fibonacci LFSR, filtered into a keystream byte.
// Build option PRG_NONLINEAR_FILTER_EN selects the nonlinear filter; otherwise the keystream is s[0].
module tt_um_prg_core (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam logic [31:0] SEED0 = 32'hACE1_2468;

    logic [31:0] s;
    logic [7:0]  ks;
    logic        step_d;

    logic        run;
    logic        load;
    logic [1:0]  load_idx;
    logic        out_sel;
    logic        step_req;
    logic        step_en;
    logic        fb;
    logic        z;
    logic [31:0] s_loaded;
    logic [31:0] s_load_val;
    logic        unused_ui;

    assign run      = ui_in[0];
    assign load     = ui_in[1];
    assign load_idx = ui_in[3:2];
    assign out_sel  = ui_in[4];
    assign step_req = ui_in[5];
    assign unused_ui = &{1'b0, ui_in[7:6]};

    assign step_en = ena & ~load & (run | (step_req & ~step_d));
    assign fb      = s[31] ^ s[21] ^ s[1] ^ s[0];

`ifdef PRG_NONLINEAR_FILTER_EN
    assign z = s[0] ^ s[9] ^ (s[4] & s[17]) ^ (s[12] & s[23] & s[30]);
`else
    assign z = s[0];
`endif

    // An all-zero state would lock the LFSR forever, so a load that produces it reseeds instead.
    always_comb begin
        s_loaded = s;
        s_loaded[{load_idx, 3'b000} +: 8] = uio_in;
        s_load_val = (s_loaded == 32'h0) ? SEED0 : s_loaded;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s      <= SEED0;
            ks     <= 8'h00;
            step_d <= 1'b0;
        end else if (ena) begin
            step_d <= step_req;
            if (load) begin
                s <= s_load_val;
            end else if (step_en) begin
                s  <= {s[30:0], fb};
                ks <= {ks[6:0], z};
            end
        end
    end

    assign uo_out  = out_sel ? s[7:0] : ks;
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_prg_core.sv
// Self-checking bench for tt_um_prg_core: reference model feeds a scoreboard queue of expected uo_out values.
module tb_tt_um_prg_core;

    localparam logic [31:0] SEED0 = 32'hACE1_2468;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    wire  [7:0] uo_out;
    wire  [7:0] uio_out;
    wire  [7:0] uio_oe;

    tt_um_prg_core dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [7:0] val;
    } exp_t;

    exp_t exp_q[$];
    int compared   = 0;
    int mismatched = 0;

    logic [31:0] m_s;
    logic [7:0]  m_ks;
    logic        m_sd;

    function automatic logic model_z(input logic [31:0] st);
`ifdef PRG_NONLINEAR_FILTER_EN
        return st[0] ^ st[9] ^ (st[4] & st[17]) ^ (st[12] & st[23] & st[30]);
`else
        return st[0];
`endif
    endfunction

    task automatic model_reset();
        m_s  = SEED0;
        m_ks = 8'h00;
        m_sd = 1'b0;
    endtask

    // Drive one cycle's inputs, advance the model across the coming edge, push the expected output.
    task automatic apply(input logic en, input logic [7:0] ui, input logic [7:0] uio, input string name);
        logic [31:0] t;
        ena    = en;
        ui_in  = ui;
        uio_in = uio;
        if (en) begin
            if (ui[1]) begin
                t = m_s;
                t[{ui[3:2], 3'b000} +: 8] = uio;
                if (t == 32'h0) t = SEED0;
                m_s = t;
            end else if (ui[0] | (ui[5] & ~m_sd)) begin
                m_ks = {m_ks[6:0], model_z(m_s)};
                m_s  = {m_s[30:0], m_s[31] ^ m_s[21] ^ m_s[1] ^ m_s[0]};
            end
            m_sd = ui[5];
        end
        exp_q.push_back('{name, (ui[4] ? m_s[7:0] : m_ks)});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h10;
        uio_in = 8'h00;
        #12;
        exp_q.push_back('{"reset_sel1", 8'h68});
        e = exp_q.pop_front();
        compared++;
        if (uo_out !== e.val) begin
            mismatched++;
            $display("FAIL %s: uo_out=%h expected %h", e.name, uo_out, e.val);
        end
        ui_in = 8'h00;
        #1;
        exp_q.push_back('{"reset_sel0", 8'h00});
        e = exp_q.pop_front();
        compared++;
        if (uo_out !== e.val) begin
            mismatched++;
            $display("FAIL %s: uo_out=%h expected %h", e.name, uo_out, e.val);
        end
        compared++;
        if (uio_oe !== 8'h00) begin
            mismatched++;
            $display("FAIL reset_uio_oe: uio_oe=%h expected 00", uio_oe);
        end
        compared++;
        if (uio_out !== 8'h00) begin
            mismatched++;
            $display("FAIL reset_uio_out: uio_out=%h expected 00", uio_out);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_single_step();
        exp_t e;
        apply(1'b1, 8'h10, 8'h00, "step_idle");
        tick();
        e = exp_q.pop_front();
        compared++;
        if (uo_out !== e.val) begin
            mismatched++;
            $display("FAIL %s: uo_out=%h expected %h", e.name, uo_out, e.val);
        end
        apply(1'b1, 8'h30, 8'h00, "step_rise");
        tick();
        e = exp_q.pop_front();
        compared++;
        if (uo_out !== e.val || uo_out !== 8'hD0) begin
            mismatched++;
            $display("FAIL %s: uo_out=%h expected %h (D0)", e.name, uo_out, e.val);
        end
        for (int i = 0; i < 5; i++) begin
            apply(1'b1, 8'h30, 8'h00, "step_hold");
            tick();
            e = exp_q.pop_front();
            compared++;
            if (uo_out !== e.val || uo_out !== 8'hD0) begin
                mismatched++;
                $display("FAIL %s[%0d]: uo_out=%h expected %h", e.name, i, uo_out, e.val);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            apply(1'b1, 8'h10, 8'h00, "b2b_low");
            tick();
            e = exp_q.pop_front();
            compared++;
            if (uo_out !== e.val) begin
                mismatched++;
                $display("FAIL %s[%0d]: uo_out=%h expected %h", e.name, i, uo_out, e.val);
            end
            apply(1'b1, 8'h30, 8'h00, "b2b_rise");
            tick();
            e = exp_q.pop_front();
            compared++;
            if (uo_out !== e.val) begin
                mismatched++;
                $display("FAIL %s[%0d]: uo_out=%h expected %h", e.name, i, uo_out, e.val);
            end
        end
    endtask

    task automatic test_seed_load();
        exp_t e;
        logic [7:0] seed_b [4];
        seed_b = '{8'h01, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 4; i++) begin
            apply(1'b1, 8'h12 | 8'(i << 2), seed_b[i], "seed_load");
            tick();
            e = exp_q.pop_front();
            compared++;
            if (uo_out !== e.val || uo_out !== 8'h01) begin
                mismatched++;
                $display("FAIL %s[%0d]: uo_out=%h expected %h", e.name, i, uo_out, e.val);
            end
        end
        apply(1'b1, 8'h11, 8'h00, "seed_run1");
        tick();
        e = exp_q.pop_front();
        compared++;
        if (uo_out !== e.val || uo_out !== 8'h03) begin
            mismatched++;
            $display("FAIL %s: uo_out=%h expected %h (03)", e.name, uo_out, e.val);
        end
    endtask

    task automatic test_lockup();
        exp_t e;
        apply(1'b1, 8'h12, 8'h01, "lock_pre");
        tick();
        e = exp_q.pop_front();
        compared++;
        if (uo_out !== e.val) begin
            mismatched++;
            $display("FAIL %s: uo_out=%h expected %h", e.name, uo_out, e.val);
        end
        for (int i = 3; i >= 0; i--) begin
            apply(1'b1, 8'h12 | 8'(i << 2), 8'h00, "lock_zero");
            tick();
            e = exp_q.pop_front();
            compared++;
            if (uo_out !== e.val) begin
                mismatched++;
                $display("FAIL %s[%0d]: uo_out=%h expected %h", e.name, i, uo_out, e.val);
            end
        end
        compared++;
        if (uo_out !== 8'h68) begin
            mismatched++;
            $display("FAIL lock_seed0: uo_out=%h expected 68", uo_out);
        end
        // Upper state bits only become visible after a few steps; this separates SEED0 from a bare 0x68.
        for (int i = 0; i < 6; i++) begin
            apply(1'b1, 8'h11, 8'h00, "lock_run");
            tick();
            e = exp_q.pop_front();
            compared++;
            if (uo_out !== e.val) begin
                mismatched++;
                $display("FAIL %s[%0d]: uo_out=%h expected %h", e.name, i, uo_out, e.val);
            end
        end
    endtask

    task automatic test_priority();
        exp_t e;
        apply(1'b1, 8'h13, 8'h5A, "prio_load_run");
        tick();
        e = exp_q.pop_front();
        compared++;
        if (uo_out !== e.val || uo_out !== 8'h5A) begin
            mismatched++;
            $display("FAIL %s: uo_out=%h expected %h (5A)", e.name, uo_out, e.val);
        end
        apply(1'b1, 8'h0B, 8'hC3, "prio_ks_hold");
        tick();
        e = exp_q.pop_front();
        compared++;
        if (uo_out !== e.val) begin
            mismatched++;
            $display("FAIL %s: uo_out=%h expected %h", e.name, uo_out, e.val);
        end
        apply(1'b1, 8'h11, 8'h00, "prio_run");
        tick();
        e = exp_q.pop_front();
        compared++;
        if (uo_out !== e.val) begin
            mismatched++;
            $display("FAIL %s: uo_out=%h expected %h", e.name, uo_out, e.val);
        end
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 8'h11, 8'h00, "ena_freeze");
            tick();
            e = exp_q.pop_front();
            compared++;
            if (uo_out !== e.val) begin
                mismatched++;
                $display("FAIL %s[%0d]: uo_out=%h expected %h", e.name, i, uo_out, e.val);
            end
        end
        apply(1'b0, 8'h12, 8'hFF, "ena_no_load");
        tick();
        e = exp_q.pop_front();
        compared++;
        if (uo_out !== e.val) begin
            mismatched++;
            $display("FAIL %s: uo_out=%h expected %h", e.name, uo_out, e.val);
        end
        apply(1'b0, 8'h30, 8'h00, "ena_step_frozen");
        tick();
        e = exp_q.pop_front();
        compared++;
        if (uo_out !== e.val) begin
            mismatched++;
            $display("FAIL %s: uo_out=%h expected %h", e.name, uo_out, e.val);
        end
        apply(1'b1, 8'h30, 8'h00, "ena_step_resume");
        tick();
        e = exp_q.pop_front();
        compared++;
        if (uo_out !== e.val) begin
            mismatched++;
            $display("FAIL %s: uo_out=%h expected %h", e.name, uo_out, e.val);
        end
    endtask

    task automatic test_keystream();
        exp_t e;
        ui_in = 8'h00;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 8; i++) begin
            apply(1'b1, 8'h01, 8'h00, "keystream");
            tick();
            e = exp_q.pop_front();
            compared++;
            if (uo_out !== e.val) begin
                mismatched++;
                $display("FAIL %s[%0d]: uo_out=%h expected %h", e.name, i, uo_out, e.val);
            end
        end
        apply(1'b1, 8'h10, 8'h00, "ks_raw_sel");
        #1;
        e = exp_q.pop_front();
        compared++;
        if (uo_out !== e.val) begin
            mismatched++;
            $display("FAIL %s: uo_out=%h expected %h", e.name, uo_out, e.val);
        end
        tick();
    endtask

    task automatic test_async_reset();
        exp_t e;
        apply(1'b1, 8'h01, 8'h00, "ar_run");
        tick();
        e = exp_q.pop_front();
        compared++;
        if (uo_out !== e.val) begin
            mismatched++;
            $display("FAIL %s: uo_out=%h expected %h", e.name, uo_out, e.val);
        end
        #3;
        rst_n = 1'b0;
        ui_in = 8'h00;
        #1;
        exp_q.push_back('{"ar_ks", 8'h00});
        e = exp_q.pop_front();
        compared++;
        if (uo_out !== e.val) begin
            mismatched++;
            $display("FAIL %s: uo_out=%h expected %h", e.name, uo_out, e.val);
        end
        ui_in = 8'h11;
        #1;
        exp_q.push_back('{"ar_raw", 8'h68});
        e = exp_q.pop_front();
        compared++;
        if (uo_out !== e.val) begin
            mismatched++;
            $display("FAIL %s: uo_out=%h expected %h", e.name, uo_out, e.val);
        end
        @(posedge clk);
        #1;
        compared++;
        if (uo_out !== 8'h68) begin
            mismatched++;
            $display("FAIL ar_held: uo_out=%h expected 68", uo_out);
        end
        rst_n = 1'b1;
        model_reset();
        apply(1'b1, 8'h11, 8'h00, "ar_after");
        tick();
        e = exp_q.pop_front();
        compared++;
        if (uo_out !== e.val) begin
            mismatched++;
            $display("FAIL %s: uo_out=%h expected %h", e.name, uo_out, e.val);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_step();
        test_back_to_back();
        test_seed_load();
        test_lockup();
        test_priority();
        test_keystream();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/tt_um_prg_core.md
# tt_um_prg_core

Boolean pseudo-random generator for the Tiny Tapeout wrapper, instantiated under the top-level name `tt_um_prg`. It is a 32-bit Fibonacci LFSR whose state feeds a nonlinear Boolean filter function, giving one keystream bit per step. Keystream bits shift into an 8-bit output register that drives the dedicated outputs. A seed loads byte-wise through the bidirectional pins, which are inputs only.

## Interface
- No parameters.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `ena` input 1: design selected. While low, all registers hold.
- `ui_in` input 8: control.
  - [0] run: step every cycle.
  - [1] load: write a seed byte.
  - [3:2] load byte index (0 = bits 7:0 … 3 = bits 31:24).
  - [4] output select: 0 = keystream byte, 1 = raw LFSR bits 7:0.
  - [5] single-step request (rising edge).
  - [7:6] unused.
- `uio_in` input 8: seed byte data.
- `uo_out` output 8: selected output byte.
- `uio_out` output 8: tied to 8'h00.
- `uio_oe` output 8: tied to 8'h00, so all uio pins are inputs.

## Operation
- **State registers:**
  - `s[31:0]` LFSR state; reset value 32'hACE1_2468 (SEED0).
  - `ks[7:0]` keystream shift register; reset value 8'h00.
  - `step_d` registered `ui_in[5]`; reset value 0.
- **Step:**
  - Keystream bit `z` = f(s), computed from the pre-update state.
  - `ks <= {ks[6:0], z}`.
  - `s <= {s[30:0], fb}`, where fb = s[31]^s[21]^s[1]^s[0] (polynomial x^32+x^22+x^2+x+1, period 2^32−1).
- **Filter function:** f(s) = s[0] ^ s[9] ^ (s[4]&s[17]) ^ (s[12]&s[23]&s[30]).
- **Step condition:** ena & ~load & (run | (ui_in[5] & ~step_d)).
- **Load:** when ena & ui_in[1], byte `ui_in[3:2]` of s is replaced by `uio_in`.
  - If the resulting 32-bit value is zero, s is set to SEED0 instead (lock-up guard).
  - ks is unchanged by a load.
- **Priority:** load beats run and step. A load cycle never steps.
- **Edge register:** `step_d` updates every cycle ena is high, including load cycles.
- **Output:** `uo_out` = ui_in[4] ? s[7:0] : ks. It is combinational from registers and `ui_in[4]`.
- **Reset:** asynchronous reset mid-operation immediately forces s = SEED0, ks = 0, step_d = 0. `uo_out` therefore reads 8'h00, or 8'h68 with select = 1.

## Timing
- One step per qualifying clock edge. With run held high, the keystream is 1 bit per cycle.
- A full new keystream byte appears in `ks` 8 cycles after run asserts.
- Single-step has 1-cycle latency from the rising edge of `ui_in[5]`. Holding `ui_in[5]` high yields exactly one step.
- A loaded byte is visible on `uo_out` (select = 1, index 0) the cycle after the load edge.
- Output-select changes take effect combinationally in the same cycle.
- ena low: no load, no step, `step_d` frozen. Outputs keep showing held values.

## Configuration
- **`PRG_NONLINEAR_FILTER_EN` defined:** z = f(s) as specified.
- **`PRG_NONLINEAR_FILTER_EN` undefined:** z = s[0] (plain LFSR output bit), with the filter logic removed.
- All other behaviour is identical in both builds.

## Test plan
- **Reset:** pulse rst_n low with ena = 1 and select = 1 → `uo_out` = 8'h68; select = 0 → 8'h00; `uio_oe` = 8'h00; `uio_out` = 8'h00.
- **Single step from reset:** one rising edge on ui_in[5] with select = 1 → `uo_out` = 8'hD0 (s = 32'h59C2_48D0). Holding ui_in[5] high 5 more cycles → no further change.
- **Seed load:** load bytes 0x01, 0x00, 0x00, 0x00 at indices 0–3 → s = 32'h0000_0001. Then run 1 cycle with select = 1 → `uo_out` = 8'h03.
- **Lock-up guard:** load 0x00 into all four bytes from state 32'h0000_0001 → s = SEED0, and select = 1 shows 8'h68.
- **Load vs run priority:** run = 1 and load = 1 in the same cycle → state changes only by the byte write, and ks is unchanged. Deasserting ena with run = 1 → `uo_out` frozen.
- **Keystream:** after reset, run 8 cycles and compare ks against a reference model of f.
  - Repeat in a build without `PRG_NONLINEAR_FILTER_EN` and check ks equals the successive s[0] bits.
